// File: rtl/hwpe_stream_sink_earlystall.sv
// Stream-to-TCDM write sink with early stall: one registered write slot, in_ready_o low whenever that slot cannot drain this cycle.
// Optional stall-cycle counter output stall_cnt_o is built when HWPE_SINK_STALL_CNT_EN is defined.
module hwpe_stream_sink_earlystall #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   stride_i,
  input  logic [CNT_WIDTH-1:0]    word_count_i,
  input  logic                    in_valid_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  output logic                    in_ready_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef HWPE_SINK_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]    stall_cnt_o
`endif
);

  // Handshakes: a stream beat moves when in_valid_i && in_ready_o; a TCDM
  // write completes when tcdm_req_o && tcdm_gnt_i. Request payload is held
  // stable from request until grant.

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [CNT_WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_WIDTH-1:0]    wr_q, wr_d;
  logic                    out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

  logic sync_clr;
  logic job_start;
  logic beat;
  logic grant;
  logic last_grant;

  assign sync_clr   = rst_i | clear_i;
  assign job_start  = (state_q == IDLE) && start_i;
  assign beat       = in_valid_i && in_ready_o;
  assign grant      = out_valid_q && tcdm_gnt_i;
  assign last_grant = grant && (wr_q == count_q - CNT_ONE);

  always_ff @(posedge clk_i) begin
    if (sync_clr) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      stride_q    <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      wr_q        <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      stride_q    <= stride_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      wr_q        <= wr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (word_count_i == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_grant) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A grant and a new beat in the same cycle overwrite the slot directly.
  always_comb begin
    next_addr_d = next_addr_q;
    stride_d    = stride_q;
    count_d     = count_q;
    acc_d       = acc_q;
    wr_d        = wr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (job_start) begin
      next_addr_d = base_addr_i;
      stride_d    = stride_i;
      count_d     = word_count_i;
      acc_d       = '0;
      wr_d        = '0;
    end
    if (grant) begin
      wr_d        = wr_q + CNT_ONE;
      out_valid_d = 1'b0;
    end
    if (beat) begin
      out_valid_d = 1'b1;
      out_addr_d  = next_addr_q;
      out_data_d  = in_data_i;
      next_addr_d = next_addr_q + stride_q;
      acc_d       = acc_q + CNT_ONE;
    end
  end

  always_comb begin
    in_ready_o  = (state_q == RUN) && !sync_clr &&
                  (!out_valid_q || tcdm_gnt_i) && (acc_q < count_q);
    tcdm_req_o  = out_valid_q;
    tcdm_add_o  = out_addr_q;
    tcdm_data_o = out_data_q;
    tcdm_wen_o  = !out_valid_q;
    tcdm_be_o   = {(DATA_WIDTH/8){out_valid_q}};
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
  end

`ifdef HWPE_SINK_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (job_start) begin
      stall_d = '0;
    end else if ((state_q == RUN) && out_valid_q && !tcdm_gnt_i && (stall_q != '1)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_clr) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: doc/hwpe_stream_sink_earlystall.md
HWPE_STREAM_SINK_EARLYSTALL -- requirements
Module: hwpe_stream_sink_earlystall

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream and TCDM data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, TCDM byte-address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of word counters.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port clear_i  input  1  synchronous local clear, same effect as rst_i.
REQ-007 SHALL have port start_i  input  1  one-cycle job start pulse.
REQ-008 SHALL have port base_addr_i  input  ADDR_WIDTH  first write byte address.
REQ-009 SHALL have port stride_i  input  ADDR_WIDTH  byte increment between words.
REQ-010 SHALL have port word_count_i  input  CNT_WIDTH  words in the job.
REQ-011 SHALL have ports in_valid_i input 1, in_data_i input DATA_WIDTH, in_ready_o output 1: incoming stream; a beat transfers when valid and ready are both high.
REQ-012 SHALL have ports tcdm_req_o output 1, tcdm_gnt_i input 1, tcdm_add_o output ADDR_WIDTH, tcdm_wen_o output 1, tcdm_data_o output DATA_WIDTH, tcdm_be_o output DATA_WIDTH/8: memory write port; a write completes when req and gnt are both high.
REQ-013 SHALL have ports busy_o output 1 (job active) and done_o output 1 (one-cycle completion pulse).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start_i with word_count_i != 0 SHALL latch base/stride/count and go to RUN; with word_count_i == 0 SHALL go to DONE.
REQ-016 start_i outside IDLE SHALL be ignored.
REQ-017 RUN: in_ready_o SHALL equal (!tcdm_req_o || tcdm_gnt_i) && (accepted < count) -- early stall, computed combinationally.
REQ-018 Accepted beat SHALL load the output register; tcdm_req_o SHALL be high the next cycle (latency 1) with tcdm_data_o = beat data.
REQ-019 tcdm_add_o for word k (0-based) SHALL be base + k*stride, modulo 2^ADDR_WIDTH (wrap, no error).
REQ-020 While tcdm_req_o is high and tcdm_gnt_i low, tcdm_add_o/tcdm_data_o SHALL stay stable.
REQ-021 Grant and new beat in the same cycle SHALL replace the register contents without a bubble (full throughput 1 word/cycle).
REQ-022 tcdm_wen_o SHALL be 0 (write) and tcdm_be_o all-ones whenever tcdm_req_o is high.
REQ-023 RUN to DONE when the count-th word is granted; DONE SHALL assert done_o for exactly one cycle then return to IDLE.
REQ-024 busy_o SHALL be high in RUN and DONE, low in IDLE.
REQ-025 A valid beat in IDLE or DONE SHALL see in_ready_o = 0.

Reset
REQ-026 rst_i or clear_i high SHALL force IDLE, counters 0, output register empty; rst_i/clear_i beat start_i in the same cycle.
REQ-027 In reset: in_ready_o=0, tcdm_req_o=0, tcdm_add_o=0, tcdm_data_o=0, tcdm_wen_o=1, tcdm_be_o=0, busy_o=0, done_o=0.
REQ-028 Reset mid-job SHALL drop tcdm_req_o the next cycle, with no done_o pulse.

Configuration
REQ-029 With macro HWPE_SINK_STALL_CNT_EN defined, SHALL add output stall_cnt_o (CNT_WIDTH): counts RUN cycles with tcdm_req_o && !tcdm_gnt_i, saturates at all-ones, clears on start; without it the port and counter SHALL not exist.

Verification
REQ-030 base=0x100, stride=4, count=4, valid always, gnt always -> writes at 0x100,0x104,0x108,0x10C on 4 consecutive cycles, done_o 1 cycle after last grant.
REQ-031 count=3, gnt low for 2 cycles on word 1 -> address 0x104 and data held stable, in_ready_o=0 in those cycles, stall_cnt_o=2 with macro.
REQ-032 count=0 start -> done_o next cycle, no tcdm_req_o.
REQ-033 base=0xFFFFFFFC, stride=8, count=2 -> addresses 0xFFFFFFFC then 0x00000004.
REQ-034 rst_i asserted after 2 of 5 words -> tcdm_req_o=0 next cycle, busy_o=0, no done_o; new start runs a clean job.
REQ-035 start_i pulsed during RUN -> ignored; job completes with original parameters.
